// File: rtl/mem_access_seq_pkg.sv
// rtl/mem_access_seq_pkg.sv - shared types and encodings for the memory-access sequencer
package mem_seq_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ACCESS     = 3'd1,
        LATCH      = 3'd2,
        EXC_SAVE   = 3'd3,
        EXC_ACCESS = 3'd4,
        EXC_LOAD   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } kind_t;

    localparam logic [2:0] SEL_ALU    = 3'b000;
    localparam logic [2:0] SEL_ALUOUT = 3'b001;
    localparam logic [2:0] SEL_V253   = 3'b010;
    localparam logic [2:0] SEL_V254   = 3'b011;
    localparam logic [2:0] SEL_V255   = 3'b100;

    localparam logic [1:0] CAUSE_NONE   = 2'b00;
    localparam logic [1:0] CAUSE_OPCODE = 2'b01;
    localparam logic [1:0] CAUSE_OVF    = 2'b10;
    localparam logic [1:0] CAUSE_DIV0   = 2'b11;

    // Each exception cause owns one fixed vector address at the top of memory.
    function automatic logic [2:0] vec_sel(input logic [1:0] cause);
        case (cause)
            CAUSE_OPCODE: vec_sel = SEL_V253;
            CAUSE_OVF:    vec_sel = SEL_V254;
            CAUSE_DIV0:   vec_sel = SEL_V255;
            default:      vec_sel = SEL_ALU;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// rtl/mem_access_seq_if.sv - request/strobe bundle between main control and the sequencer
interface mem_access_seq_if;
    logic       req_fetch;
    logic       req_load;
    logic       req_store;
    logic       exc_opcode;
    logic       exc_ovf;
    logic       exc_div0;
    logic [2:0] iord_sel;
    logic       mem_wr;
    logic       ir_wr;
    logic       mdr_wr;
    logic       epc_wr;
    logic       pc_wr;
    logic       pc_src_exc;
    logic [1:0] cause;
    logic       busy;
    logic       done;

    modport master (
        output req_fetch, req_load, req_store, exc_opcode, exc_ovf, exc_div0,
        input  iord_sel, mem_wr, ir_wr, mdr_wr, epc_wr, pc_wr, pc_src_exc,
               cause, busy, done
    );

    modport slave (
        input  req_fetch, req_load, req_store, exc_opcode, exc_ovf, exc_div0,
        output iord_sel, mem_wr, ir_wr, mdr_wr, epc_wr, pc_wr, pc_src_exc,
               cause, busy, done
    );
endinterface

// File: rtl/mem_wait_cnt.sv
// rtl/mem_wait_cnt.sv - loadable down-counter timing memory wait cycles
module mem_wait_cnt #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; decrement saturates at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign count = cnt;
    assign last  = (cnt == CNT_W'(1));

endmodule

// File: rtl/mem_access_seq.sv
// rtl/mem_access_seq.sv - multicycle sequencer for fetch, load/store and exception-vector reads
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    mem_access_seq_if.slave  bus
);

    state_t           state, state_nx;
    kind_t            kind;
    logic [1:0]       cause_q;
    logic             cnt_load, cnt_dec, cnt_last;
    logic [CNT_W-1:0] cnt;
    logic             exc_any, mem_any;
    logic [1:0]       exc_code;

    logic [2:0] iord_sel;
    logic       mem_wr, ir_wr, mdr_wr, epc_wr, pc_wr, pc_src_exc, done;

    assign exc_any = bus.exc_opcode | bus.exc_ovf | bus.exc_div0;
    assign mem_any = bus.req_fetch | bus.req_load | bus.req_store;

    // Only the highest-priority exception is ever recorded.
    always_comb begin
        exc_code = CAUSE_NONE;
        if (bus.exc_opcode)   exc_code = CAUSE_OPCODE;
        else if (bus.exc_ovf) exc_code = CAUSE_OVF;
        else if (bus.exc_div0) exc_code = CAUSE_DIV0;
    end

    mem_wait_cnt #(.CNT_W(CNT_W)) u_wait_cnt (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (cnt_load),
        .load_val (CNT_W'(MEM_LAT)),
        .dec      (cnt_dec),
        .count    (cnt),
        .last     (cnt_last)
    );

    // Next-state logic; requests are only looked at in IDLE.
    always_comb begin
        state_nx = state;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state)
            IDLE: begin
                if (exc_any) begin
                    state_nx = EXC_SAVE;
                end else if (mem_any) begin
                    state_nx = ACCESS;
                    cnt_load = 1'b1;
                end
            end
            ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_last) state_nx = LATCH;
            end
            LATCH:    state_nx = IDLE;
            EXC_SAVE: begin
                state_nx = EXC_ACCESS;
                cnt_load = 1'b1;
            end
            EXC_ACCESS: begin
                cnt_dec = 1'b1;
                if (cnt_last) state_nx = EXC_LOAD;
            end
            EXC_LOAD: state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // State register plus the access kind / cause captured at acceptance.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            kind    <= FETCH;
            cause_q <= CAUSE_NONE;
        end else begin
            state <= state_nx;
            if (state == IDLE) begin
                if (exc_any) begin
                    cause_q <= exc_code;
                end else if (bus.req_load) begin
                    kind <= LOAD;
                end else if (bus.req_store) begin
                    kind <= STORE;
                end else if (bus.req_fetch) begin
                    kind <= FETCH;
                end
            end
        end
    end

    // Moore output decode: strobes depend only on registered state.
    always_comb begin
        iord_sel   = SEL_ALU;
        mem_wr     = 1'b0;
        ir_wr      = 1'b0;
        mdr_wr     = 1'b0;
        epc_wr     = 1'b0;
        pc_wr      = 1'b0;
        pc_src_exc = 1'b0;
        done       = 1'b0;
        case (state)
            ACCESS: begin
                iord_sel = (kind == FETCH) ? SEL_ALU : SEL_ALUOUT;
                // Write strobe only while the counter still holds its loaded value.
                mem_wr   = (kind == STORE) && (cnt == CNT_W'(MEM_LAT));
            end
            LATCH: begin
                iord_sel = (kind == FETCH) ? SEL_ALU : SEL_ALUOUT;
                ir_wr    = (kind == FETCH);
                mdr_wr   = (kind == LOAD);
                done     = 1'b1;
            end
            EXC_SAVE: begin
                iord_sel = vec_sel(cause_q);
                epc_wr   = 1'b1;
            end
            EXC_ACCESS: iord_sel = vec_sel(cause_q);
            EXC_LOAD: begin
                iord_sel   = vec_sel(cause_q);
                mdr_wr     = 1'b1;
                pc_src_exc = 1'b1;
                pc_wr      = 1'b1;
                done       = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.iord_sel   = iord_sel;
    assign bus.mem_wr     = mem_wr;
    assign bus.ir_wr      = ir_wr;
    assign bus.mdr_wr     = mdr_wr;
    assign bus.epc_wr     = epc_wr;
    assign bus.pc_wr      = pc_wr;
    assign bus.pc_src_exc = pc_src_exc;
    assign bus.cause      = cause_q;
    assign bus.busy       = (state != IDLE);
    assign bus.done       = done;

endmodule

// File: tb/tb_mem_access_seq.sv
// tb/tb_mem_access_seq.sv - directed self-checking bench for mem_access_seq
module tb_mem_access_seq;

    logic clk = 1'b0;
    logic reset_n;
    logic req_fetch, req_load, req_store, exc_opcode, exc_ovf, exc_div0;

    always #5 clk = ~clk;

    // {iord_sel, mem_wr, ir_wr, mdr_wr, epc_wr, pc_wr, pc_src_exc, cause, busy, done}
    logic [12:0] obs_v [3];
    logic [12:0] obs;
    int          dsel;
    int          total = 0;
    int          bad   = 0;
    int          ndone = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mem_access_seq_if bus_i ();
        assign bus_i.req_fetch  = req_fetch;
        assign bus_i.req_load   = req_load;
        assign bus_i.req_store  = req_store;
        assign bus_i.exc_opcode = exc_opcode;
        assign bus_i.exc_ovf    = exc_ovf;
        assign bus_i.exc_div0   = exc_div0;
        assign obs_v[g] = {bus_i.iord_sel, bus_i.mem_wr, bus_i.ir_wr, bus_i.mdr_wr,
                           bus_i.epc_wr, bus_i.pc_wr, bus_i.pc_src_exc, bus_i.cause,
                           bus_i.busy, bus_i.done};
        mem_access_seq #(.MEM_LAT(g + 1), .CNT_W(4)) u_dut (
            .clk     (clk),
            .reset_n (reset_n),
            .bus     (bus_i)
        );
    end

    assign obs = obs_v[dsel];

    function automatic logic [12:0] mk(input logic [2:0] sel, input logic mw, ir, mdr,
                                       epc, pcw, pcx, input logic [1:0] c, input logic b, d);
        return {sel, mw, ir, mdr, epc, pcw, pcx, c, b, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [12:0] exp);
        @(posedge clk);
        #1;
        if (obs[0] === 1'b1) ndone++;
        check(tag, 32'(obs), 32'(exp));
    endtask

    task automatic drop_reqs();
        req_fetch = 0; req_load = 0; req_store = 0;
        exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    endtask

    task automatic do_reset();
        drop_reqs();
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        dsel = 0;
        do_reset();
        check("reset_state", 32'(obs), 32'(mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0)));

        // Fetch, MEM_LAT=1, request held through done then re-accepted
        req_fetch = 1;
        step("f_acc",    mk(3'b000, 0,0,0,0,0,0, 2'b00, 1, 0));
        step("f_latch",  mk(3'b000, 0,1,0,0,0,0, 2'b00, 1, 1));
        step("f_idle",   mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));
        step("f_reacc",  mk(3'b000, 0,0,0,0,0,0, 2'b00, 1, 0));
        req_fetch = 0;
        step("f_latch2", mk(3'b000, 0,1,0,0,0,0, 2'b00, 1, 1));
        step("f_idle2",  mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));

        // Store, MEM_LAT=3
        dsel = 2;
        do_reset();
        req_store = 1;
        step("s_acc1",  mk(3'b001, 1,0,0,0,0,0, 2'b00, 1, 0));
        step("s_acc2",  mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 0));
        step("s_acc3",  mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 0));
        step("s_latch", mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 1));
        req_store = 0;
        step("s_idle",  mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));

        // Reset in the middle of a load, MEM_LAT=2
        dsel = 1;
        do_reset();
        req_load = 1;
        step("r_acc1", mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 0));
        step("r_acc2", mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 0));
        reset_n = 1'b0;
        #1;
        check("r_async", 32'(obs), 32'(mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0)));
        drop_reqs();
        step("r_hold", mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));
        reset_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 4; i++)
            step("r_after", mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));
        check("r_no_done", 32'(ndone), 32'd0);

        // Simultaneous ovf + div0 + load, MEM_LAT=2
        do_reset();
        exc_ovf = 1; exc_div0 = 1; req_load = 1;
        step("x_save", mk(3'b011, 0,0,0,1,0,0, 2'b10, 1, 0));
        step("x_acc1", mk(3'b011, 0,0,0,0,0,0, 2'b10, 1, 0));
        step("x_acc2", mk(3'b011, 0,0,0,0,0,0, 2'b10, 1, 0));
        step("x_load", mk(3'b011, 0,0,1,0,1,1, 2'b10, 1, 1));
        drop_reqs();
        step("x_idle", mk(3'b000, 0,0,0,0,0,0, 2'b10, 0, 0));
        step("x_idle2", mk(3'b000, 0,0,0,0,0,0, 2'b10, 0, 0));

        // Opcode exception then div0, MEM_LAT=1
        dsel = 0;
        do_reset();
        exc_opcode = 1;
        step("o_save", mk(3'b010, 0,0,0,1,0,0, 2'b01, 1, 0));
        step("o_acc",  mk(3'b010, 0,0,0,0,0,0, 2'b01, 1, 0));
        step("o_load", mk(3'b010, 0,0,1,0,1,1, 2'b01, 1, 1));
        drop_reqs();
        step("o_idle", mk(3'b000, 0,0,0,0,0,0, 2'b01, 0, 0));
        exc_div0 = 1;
        step("d_save", mk(3'b100, 0,0,0,1,0,0, 2'b11, 1, 0));
        step("d_acc",  mk(3'b100, 0,0,0,0,0,0, 2'b11, 1, 0));
        step("d_load", mk(3'b100, 0,0,1,0,1,1, 2'b11, 1, 1));
        drop_reqs();
        step("d_idle", mk(3'b000, 0,0,0,0,0,0, 2'b11, 0, 0));

        // Fetch pulsed while a load is in ACCESS, MEM_LAT=3
        dsel = 2;
        do_reset();
        ndone = 0;
        req_load = 1;
        step("b_acc1",  mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 0));
        req_fetch = 1;
        step("b_acc2",  mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 0));
        req_fetch = 0;
        step("b_acc3",  mk(3'b001, 0,0,0,0,0,0, 2'b00, 1, 0));
        step("b_latch", mk(3'b001, 0,0,1,0,0,0, 2'b00, 1, 1));
        req_load = 0;
        step("b_idle",  mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));
        step("b_idle2", mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));
        step("b_idle3", mk(3'b000, 0,0,0,0,0,0, 2'b00, 0, 0));
        check("b_one_done", 32'(ndone), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
